// File: rtl/lii_pkg.sv
// Shared constants, types and the round-robin search helper for the LII packers.
package lii_pkg;
    localparam int LII_ID_W       = 8;
    localparam int LII_PW_DEFAULT = 256;
    localparam int LII_FIFO_DEPTH = 2;

    typedef logic [LII_ID_W-1:0] lii_id_t;

    // First requester strictly after ptr, wrapping modulo n; returns ptr when nothing requests.
    function automatic logic [1:0] rr_next(input logic [1:0] ptr, input logic [3:0] req, input int n);
        logic [1:0] g;
        int         idx;
        g = ptr;
        for (int k = n; k >= 1; k--) begin
            idx = (int'(ptr) + k) % n;
            if (req[idx[1:0]]) g = idx[1:0];
        end
        return g;
    endfunction
endpackage

// File: rtl/lii_out_packer_if.sv
// Kernel-side streams plus the LII physical output channel of the packer.
interface lii_out_packer_if
    import lii_pkg::*;
#(
    parameter int NOUT = 2,
    parameter int DW   = 160,
    parameter int PW   = LII_PW_DEFAULT
);
    logic [NOUT*DW-1:0] s_tdata;
    logic [NOUT-1:0]    s_tvalid;
    logic [NOUT-1:0]    s_tready;
    logic [PW-1:0]      lii_out_p0_tdata;
    logic               lii_out_p0_tvalid;
    logic               lii_out_p0_tready;
    lii_id_t            lii_out_p0_src;
    lii_id_t            lii_out_p0_dst;

    modport slave (
        input  s_tdata, s_tvalid, lii_out_p0_tready,
        output s_tready, lii_out_p0_tdata, lii_out_p0_tvalid, lii_out_p0_src, lii_out_p0_dst
    );

    modport master (
        output s_tdata, s_tvalid, lii_out_p0_tready,
        input  s_tready, lii_out_p0_tdata, lii_out_p0_tvalid, lii_out_p0_src, lii_out_p0_dst
    );
endinterface

// File: rtl/lii_skid_fifo2.sv
// Two-entry FIFO between the arbiter and the LII channel; also produces the kernel clock enable.
module lii_skid_fifo2
    import lii_pkg::*;
#(
    parameter int W = LII_ID_W + LII_PW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic [W-1:0] head_data,
    output logic         valid,
    output logic         full,
    output logic         pop,
    output logic         ce
);
    logic [W-1:0] mem [LII_FIFO_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic [1:0]   count_nxt;

    assign full      = (count == 2'(LII_FIFO_DEPTH));
    assign valid     = (count != 2'd0);
    assign pop       = valid & pop_ready;
    assign head_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // ce comes from the next-state count so it is a clean flop output aligned with full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            ce     <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_nxt;
            ce    <= (count_nxt != 2'(LII_FIFO_DEPTH));
        end
    end
endmodule

// File: rtl/lii_out_packer.sv
// Round-robin packs NOUT kernel streams onto one LII output channel with src/dst tagging.
module lii_out_packer
    import lii_pkg::*;
#(
    parameter int                         NOUT    = 2,
    parameter int                         DW      = 160,
    parameter int                         PW      = LII_PW_DEFAULT,
    parameter logic [LII_ID_W-1:0]        SRC_ID  = 8'h00,
    parameter logic [NOUT*LII_ID_W-1:0]   DST_IDS = {8'h01, 8'h00}
) (
    input  logic                aclk,
    input  logic                arstn,
    lii_out_packer_if.slave     bus,
    output logic                ce,
    output logic [31:0]         beat_cnt
);
    localparam int EW = LII_ID_W + PW;

    logic [1:0]    ptr;
    logic [1:0]    gnt;
    logic [3:0]    req;
    logic          any_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          fifo_valid;
    logic [DW-1:0] gnt_data;
    lii_id_t       gnt_dst;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;

    // Grant is purely a function of ptr, valids and fullness -- never of the phy ready.
    always_comb begin
        req              = '0;
        req[NOUT-1:0]    = bus.s_tvalid;
        gnt              = rr_next(ptr, req, NOUT);
        any_req          = |bus.s_tvalid;
        push             = any_req & ~full;
        bus.s_tready     = '0;
        for (int i = 0; i < NOUT; i++) bus.s_tready[i] = push && (gnt == 2'(i));
        gnt_data         = bus.s_tdata[int'(gnt)*DW +: DW];
        gnt_dst          = DST_IDS[int'(gnt)*LII_ID_W +: LII_ID_W];
        push_entry       = {gnt_dst, PW'(gnt_data)};
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            ptr <= 2'(NOUT - 1);
        end else if (push) begin
            ptr <= gnt;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end

    lii_skid_fifo2 #(.W(EW)) u_fifo (
        .clk       (aclk),
        .rst_n     (arstn),
        .push      (push),
        .push_data (push_entry),
        .pop_ready (bus.lii_out_p0_tready),
        .head_data (head_entry),
        .valid     (fifo_valid),
        .full      (full),
        .pop       (pop),
        .ce        (ce)
    );

    assign bus.lii_out_p0_tvalid = fifo_valid;
    assign bus.lii_out_p0_tdata  = head_entry[PW-1:0];
    assign bus.lii_out_p0_dst    = head_entry[EW-1 -: LII_ID_W];
    assign bus.lii_out_p0_src    = SRC_ID;
endmodule

// File: tb/tb_lii_out_packer.sv
// Scoreboard bench for lii_out_packer: directed stimulus, expected beats queued, phy monitor checks them.
module tb_lii_out_packer;
    import lii_pkg::*;

    localparam int NOUT = 2;
    localparam int DW   = 160;
    localparam int PW   = 256;
    localparam int EW   = PW + 8;

    logic        aclk = 1'b0;
    logic        arstn = 1'b0;
    logic        ce;
    logic [31:0] beat_cnt;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];

    always #5 aclk = ~aclk;

    lii_out_packer_if #(.NOUT(NOUT), .DW(DW), .PW(PW)) bus ();

    lii_out_packer #(
        .NOUT(NOUT), .DW(DW), .PW(PW), .SRC_ID(8'h00), .DST_IDS({8'h01, 8'h00})
    ) dut (
        .aclk     (aclk),
        .arstn    (arstn),
        .bus      (bus),
        .ce       (ce),
        .beat_cnt (beat_cnt)
    );

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] entry(input logic [7:0] dst, input logic [DW-1:0] d);
        return {dst, PW'(d)};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        repeat (2) @(posedge aclk);
        #3 arstn = 1'b1;
        tick();
    endtask

    // Hold stream s valid until n beats are accepted (bounded); data increments per accepted beat.
    task automatic send(input int s, input int n, input logic [DW-1:0] d0, output int cycles);
        int            sent;
        logic          acc;
        logic [DW-1:0] d;
        sent   = 0;
        cycles = 0;
        d      = d0;
        bus.s_tvalid[s]          = 1'b1;
        bus.s_tdata[s*DW +: DW]  = d;
        while (sent < n && cycles < 200) begin
            @(negedge aclk);
            acc = bus.s_tready[s];
            tick();
            cycles++;
            if (acc) begin
                sent++;
                d = d + 1'b1;
                bus.s_tdata[s*DW +: DW] = d;
            end
        end
        bus.s_tvalid[s] = 1'b0;
        check("send_accept_count", EW'(sent), EW'(n));
    endtask

    // Phy-side monitor: every handshaken beat must match the head of the expected queue.
    always @(negedge aclk) begin
        if (arstn && bus.lii_out_p0_tvalid && bus.lii_out_p0_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got %h expected none",
                         {bus.lii_out_p0_dst, bus.lii_out_p0_tdata});
            end else begin
                check("phy_beat", {bus.lii_out_p0_dst, bus.lii_out_p0_tdata}, exp_q.pop_front());
                check("phy_src", EW'(bus.lii_out_p0_src), EW'(8'h00));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            cyc;
        int            n0, n1;
        logic [1:0]    r;
        logic [DW-1:0] d0, d1;

        bus.s_tvalid          = '0;
        bus.s_tdata           = '0;
        bus.lii_out_p0_tready = 1'b0;

        // 1: reset then idle
        do_reset();
        @(negedge aclk);
        check("rst_tvalid", EW'(bus.lii_out_p0_tvalid), EW'(0));
        check("rst_ce", EW'(ce), EW'(1));
        check("rst_beat_cnt", EW'(beat_cnt), EW'(0));
        check("rst_s_tready", EW'(bus.s_tready), EW'(0));
        check("rst_head", {bus.lii_out_p0_dst, bus.lii_out_p0_tdata}, '0);
        tick();

        // 2: single stream, 4 beats of 0xA5, one cycle latency
        bus.lii_out_p0_tready = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(entry(8'h00, DW'(8'hA5)));
        bus.s_tdata[0 +: DW] = DW'(8'hA5);
        bus.s_tvalid[0]      = 1'b1;
        @(negedge aclk);
        check("s2_ready", EW'(bus.s_tready), EW'(2'b01));
        check("s2_pre_vld", EW'(bus.lii_out_p0_tvalid), EW'(0));
        tick();
        @(negedge aclk);
        check("s2_latency_vld", EW'(bus.lii_out_p0_tvalid), EW'(1));
        repeat (3) tick();
        bus.s_tvalid[0] = 1'b0;
        repeat (3) tick();
        @(negedge aclk);
        check("s2_beat_cnt", EW'(beat_cnt), EW'(4));
        check("s2_idle_vld", EW'(bus.lii_out_p0_tvalid), EW'(0));
        tick();

        // 3: fairness with both streams valid for 8 cycles
        do_reset();
        bus.lii_out_p0_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(entry(8'h00, DW'(32'h100 + k)));
            exp_q.push_back(entry(8'h01, DW'(32'h200 + k)));
        end
        d0 = DW'(32'h100);
        d1 = DW'(32'h200);
        n0 = 0;
        n1 = 0;
        bus.s_tdata  = {d1, d0};
        bus.s_tvalid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            @(negedge aclk);
            r = bus.s_tready;
            check("s3_onehot", EW'(r == 2'b11), EW'(0));
            tick();
            if (r[0]) begin n0++; d0 = d0 + 1'b1; end
            if (r[1]) begin n1++; d1 = d1 + 1'b1; end
            bus.s_tdata = {d1, d0};
        end
        bus.s_tvalid = 2'b00;
        check("s3_n0", EW'(n0), EW'(4));
        check("s3_n1", EW'(n1), EW'(4));
        repeat (3) tick();

        // 4: backpressure fills the buffer, head holds, then drains
        bus.lii_out_p0_tready = 1'b0;
        exp_q.push_back(entry(8'h01, DW'(32'h300)));
        exp_q.push_back(entry(8'h01, DW'(32'h301)));
        d1 = DW'(32'h300);
        n1 = 0;
        bus.s_tdata[DW +: DW] = d1;
        bus.s_tvalid[1]       = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            r = bus.s_tready;
            tick();
            if (r[1]) begin n1++; d1 = d1 + 1'b1; bus.s_tdata[DW +: DW] = d1; end
        end
        check("s4_accepted", EW'(n1), EW'(2));
        @(negedge aclk);
        check("s4_full_ready", EW'(bus.s_tready), EW'(0));
        check("s4_full_ce", EW'(ce), EW'(0));
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            check("s4_head_hold", {bus.lii_out_p0_dst, bus.lii_out_p0_tdata}, entry(8'h01, DW'(32'h300)));
        end
        tick();
        bus.s_tvalid[1]       = 1'b0;
        bus.lii_out_p0_tready = 1'b1;
        @(negedge aclk);
        check("s4_ce_at_pop", EW'(ce), EW'(0));
        tick();
        @(negedge aclk);
        check("s4_ce_after_pop", EW'(ce), EW'(1));
        repeat (2) tick();

        // 5: streaming at count=1 with simultaneous push and pop
        for (int k = 0; k < 6; k++) exp_q.push_back(entry(8'h00, DW'(32'h400 + k)));
        send(0, 6, DW'(32'h400), cyc);
        check("s5_cycles", EW'(cyc), EW'(6));
        @(negedge aclk);
        check("s5_ce", EW'(ce), EW'(1));
        repeat (3) tick();
        check("s5_drained", EW'(exp_q.size()), EW'(0));

        // 6: async reset with a full buffer, then stream0 wins first
        bus.lii_out_p0_tready = 1'b0;
        send(0, 2, DW'(32'h500), cyc);
        @(negedge aclk);
        check("s6_full_ce", EW'(ce), EW'(0));
        bus.s_tdata  = {DW'(32'h700), DW'(32'h600)};
        bus.s_tvalid = 2'b11;
        #2 arstn = 1'b0;
        #1;
        check("s6_rst_tvalid", EW'(bus.lii_out_p0_tvalid), EW'(0));
        check("s6_rst_beat_cnt", EW'(beat_cnt), EW'(0));
        check("s6_rst_ce", EW'(ce), EW'(1));
        @(posedge aclk);
        #3 arstn = 1'b1;
        exp_q.push_back(entry(8'h00, DW'(32'h600)));
        bus.lii_out_p0_tready = 1'b1;
        @(negedge aclk);
        check("s6_first_grant", EW'(bus.s_tready), EW'(2'b01));
        tick();
        bus.s_tvalid = 2'b00;
        repeat (3) tick();
        @(negedge aclk);
        check("s6_beat_cnt", EW'(beat_cnt), EW'(1));
        check("final_queue_empty", EW'(exp_q.size()), EW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
